// File: rtl/subpixel_offset_solver.sv
// subpixel_offset_solver: SIFT sub-pixel offset -(adj(H)*grad)/det(H) via three restoring dividers.
// Define OFFSET_ROUND_EN for one guard-bit iteration and half-up rounding of the quotient.
module subpixel_offset_solver #(
    parameter int FRAC_BITS = 8
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    ivalid,
    output logic                    oready,
    input  logic [8:0]              iadj11,
    input  logic [8:0]              iadj12,
    input  logic [8:0]              iadj13,
    input  logic [8:0]              iadj21,
    input  logic [8:0]              iadj22,
    input  logic [8:0]              iadj23,
    input  logic [8:0]              iadj31,
    input  logic [8:0]              iadj32,
    input  logic [8:0]              iadj33,
    input  logic [16:0]             idet,
    input  logic [8:0]              igrad_x,
    input  logic [8:0]              igrad_y,
    input  logic [8:0]              igrad_s,
    output logic                    ovalid,
    output logic [FRAC_BITS+3:0]    ooff_x,
    output logic [FRAC_BITS+3:0]    ooff_y,
    output logic [FRAC_BITS+3:0]    ooff_s,
    output logic                    okeep,
    output logic                    osingular
);
    localparam int NUM_W = 20;
    localparam int OUT_W = FRAC_BITS + 4;
    localparam int DW = 17;
    localparam int RW = DW + 1;
`ifdef OFFSET_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int QW = NUM_W + FRAC_BITS + RND;
    localparam int CW = $clog2(QW + 1);
    localparam int SAT = 2 ** (OUT_W - 1) - 1;
    localparam int HALF = 2 ** (FRAC_BITS - 1);

    typedef enum logic [1:0] {IDLE, MAC, DIV, OUT} state_t;

    state_t                     state_q, state_d;
    logic [8:0][8:0]            adj_q, adj_d;
    logic [2:0][8:0]            grad_q, grad_d;
    logic [DW-1:0]              det_q, det_d;
    logic [2:0]                 neg_q, neg_d;
    logic                       sing_q, sing_d;
    logic [DW-1:0]              dsr_q, dsr_d;
    logic [2:0][DW-1:0]         rem_q, rem_d;
    logic [2:0][QW-1:0]         dvd_q, dvd_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [2:0][OUT_W-1:0]      off_q, off_d;
    logic                       okeep_q, okeep_d;
    logic                       osing_q, osing_d;
    logic                       ovalid_q, ovalid_d;

    logic signed [NUM_W-1:0]    ax [9];
    logic signed [NUM_W-1:0]    gx [3];
    logic signed [NUM_W-1:0]    num [3];
    logic [NUM_W-1:0]           mag [3];
    logic [DW-1:0]              det_abs;
    logic [RW-1:0]              trial [3];
    logic [2:0]                 ge;
    logic [DW-1:0]              rem_nx [3];
    logic [QW-1:0]              dvd_nx [3];
    logic [QW-1:0]              qmag [3];
    logic [OUT_W-1:0]           sat [3];
    logic                       keep_all;

    // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom
    always_comb begin
        for (int i = 0; i < 9; i++) ax[i] = NUM_W'($signed(adj_q[i]));
        for (int i = 0; i < 3; i++) gx[i] = NUM_W'($signed(grad_q[i]));
        det_abs = det_q[DW-1] ? -det_q : det_q;
        keep_all = 1'b1;
        for (int i = 0; i < 3; i++) begin
            num[i] = -(ax[3*i] * gx[0] + ax[3*i+1] * gx[1] + ax[3*i+2] * gx[2]);
            mag[i] = num[i][NUM_W-1] ? -num[i] : num[i];
            trial[i] = {rem_q[i], dvd_q[i][QW-1]};
            ge[i] = trial[i] >= RW'(dsr_q);
            rem_nx[i] = ge[i] ? DW'(trial[i] - RW'(dsr_q)) : DW'(trial[i]);
            dvd_nx[i] = {dvd_q[i][QW-2:0], ge[i]};
`ifdef OFFSET_ROUND_EN
            qmag[i] = (dvd_q[i] >> 1) + QW'(dvd_q[i][0]);
`else
            qmag[i] = dvd_q[i];
`endif
            sat[i] = qmag[i] > QW'(SAT) ? OUT_W'(SAT) : qmag[i][OUT_W-1:0];
            keep_all = keep_all & (sat[i] <= OUT_W'(HALF));
        end
    end

    always_comb begin
        state_d = state_q;
        adj_d = adj_q;
        grad_d = grad_q;
        det_d = det_q;
        neg_d = neg_q;
        sing_d = sing_q;
        dsr_d = dsr_q;
        rem_d = rem_q;
        dvd_d = dvd_q;
        cnt_d = cnt_q;
        off_d = off_q;
        okeep_d = okeep_q;
        osing_d = osing_q;
        ovalid_d = 1'b0;
        case (state_q)
            IDLE: if (ivalid) begin
                adj_d = {iadj33, iadj32, iadj31, iadj23, iadj22, iadj21, iadj13, iadj12, iadj11};
                grad_d = {igrad_s, igrad_y, igrad_x};
                det_d = idet;
                state_d = MAC;
            end
            MAC: begin
                for (int i = 0; i < 3; i++) begin
                    neg_d[i] = num[i][NUM_W-1] ^ det_q[DW-1];
                    dvd_d[i] = {mag[i], {(FRAC_BITS + RND){1'b0}}};
                    rem_d[i] = '0;
                end
                dsr_d = det_abs;
                sing_d = det_q == '0;
                cnt_d = '0;
                state_d = DIV;
            end
            DIV: begin
                for (int i = 0; i < 3; i++) begin
                    rem_d[i] = rem_nx[i];
                    dvd_d[i] = dvd_nx[i];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) state_d = OUT;
            end
            default: begin
                for (int i = 0; i < 3; i++)
                    off_d[i] = sing_q ? '0 : (neg_q[i] ? -sat[i] : sat[i]);
                okeep_d = !sing_q && keep_all;
                osing_d = sing_q;
                ovalid_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_q <= IDLE;
            adj_q <= '0;
            grad_q <= '0;
            det_q <= '0;
            neg_q <= '0;
            sing_q <= 1'b0;
            dsr_q <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            cnt_q <= '0;
            off_q <= '0;
            okeep_q <= 1'b0;
            osing_q <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adj_q <= adj_d;
            grad_q <= grad_d;
            det_q <= det_d;
            neg_q <= neg_d;
            sing_q <= sing_d;
            dsr_q <= dsr_d;
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_d;
            off_q <= off_d;
            okeep_q <= okeep_d;
            osing_q <= osing_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign oready = state_q == IDLE;
    assign ovalid = ovalid_q;
    assign ooff_x = off_q[0];
    assign ooff_y = off_q[1];
    assign ooff_s = off_q[2];
    assign okeep = okeep_q;
    assign osingular = osing_q;
endmodule

// File: tb/tb_subpixel_offset_solver.sv
// tb_subpixel_offset_solver: directed vectors with a queued scoreboard checked on ovalid.
module tb_subpixel_offset_solver;
    localparam int OUT_W = 12;
`ifdef OFFSET_ROUND_EN
    localparam int LAT = 31;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 30;
    localparam bit RND = 1'b0;
`endif

    logic iclk = 1'b0, irst = 1'b1, ivalid = 1'b0;
    logic oready, ovalid, okeep, osingular;
    logic [8:0] iadj11 = '0, iadj12 = '0, iadj13 = '0, iadj21 = '0, iadj22 = '0;
    logic [8:0] iadj23 = '0, iadj31 = '0, iadj32 = '0, iadj33 = '0;
    logic [8:0] igrad_x = '0, igrad_y = '0, igrad_s = '0;
    logic [16:0] idet = '0;
    logic [OUT_W-1:0] ooff_x, ooff_y, ooff_s;

    typedef struct {
        logic signed [31:0] x, y, s;
        logic keep, sing;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int n_chk = 0, n_err = 0, cyc = 0, n_ov = 0, last_acc = -1;

    subpixel_offset_solver dut (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready),
        .iadj11(iadj11), .iadj12(iadj12), .iadj13(iadj13),
        .iadj21(iadj21), .iadj22(iadj22), .iadj23(iadj23),
        .iadj31(iadj31), .iadj32(iadj32), .iadj33(iadj33),
        .idet(idet), .igrad_x(igrad_x), .igrad_y(igrad_y), .igrad_s(igrad_s),
        .ovalid(ovalid), .ooff_x(ooff_x), .ooff_y(ooff_y), .ooff_s(ooff_s),
        .okeep(okeep), .osingular(osingular)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge iclk) begin
        if (!irst && ovalid) begin
            n_ov++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ovalid: got ovalid=1, expected no result pending (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("off_x", $signed(ooff_x), e.x);
                chk("off_y", $signed(ooff_y), e.y);
                chk("off_s", $signed(ooff_s), e.s);
                chk("okeep", okeep, e.keep);
                chk("osingular", osingular, e.sing);
                chk("latency", cyc - e.acc, LAT);
                chk("oready_at_ovalid", oready, 1);
            end
        end
    end

    task automatic send(input int a11, a12, a13, a21, a22, a23, a31, a32, a33, d, gx, gy, gs,
                        input int ex, ey, es, input bit k, sg);
        int t = 0;
        while (!oready && t < 200) begin
            @(negedge iclk);
            t++;
        end
        if (!oready) begin
            n_chk++;
            n_err++;
            $display("FAIL ready_timeout: got oready=0, expected 1 within 200 cycles");
            return;
        end
        if (last_acc >= 0) chk("accept_gap", cyc + 1 - last_acc, LAT + 1);
        last_acc = cyc + 1;
        iadj11 = a11[8:0]; iadj12 = a12[8:0]; iadj13 = a13[8:0];
        iadj21 = a21[8:0]; iadj22 = a22[8:0]; iadj23 = a23[8:0];
        iadj31 = a31[8:0]; iadj32 = a32[8:0]; iadj33 = a33[8:0];
        idet = d[16:0];
        igrad_x = gx[8:0]; igrad_y = gy[8:0]; igrad_s = gs[8:0];
        exp_q.push_back('{ex, ey, es, k, sg, cyc + 1});
        ivalid = 1'b1;
        @(negedge iclk);
        ivalid = 1'b0;
    endtask

    initial begin
        int t;
        int ov0;
        repeat (3) @(negedge iclk);
        chk("rst_oready", oready, 1);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_off_x", $signed(ooff_x), 0);
        chk("rst_okeep", okeep, 0);
        chk("rst_osingular", osingular, 0);
        irst = 1'b0;
        @(negedge iclk);
        send(4,0,0, 0,4,0, 0,0,4, 8, 1,0,0, -128,0,0, 1'b1,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, 8, 2,-1,0, -256,128,0, 1'b0,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, 0, 1,2,3, 0,0,0, 1'b0,1'b1);
        send(255,0,0, 0,0,0, 0,0,0, 1, -255,0,0, 2047,0,0, 1'b0,1'b0);
        send(255,0,0, 0,0,0, 0,0,0, 1, 255,0,0, -2047,0,0, 1'b0,1'b0);
        send(-2,0,0, 0,0,0, 0,0,0, 3, 1,0,0, RND ? 171 : 170,0,0, 1'b0,1'b0);
        // ivalid while busy must be dropped
        repeat (3) @(negedge iclk);
        iadj11 = 9'd100; idet = 17'd1; igrad_x = 9'd100; ivalid = 1'b1;
        repeat (5) @(negedge iclk);
        ivalid = 1'b0;
        send(2,0,0, 0,0,0, 0,0,0, 3, 1,0,0, RND ? -171 : -170,0,0, 1'b0,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, -8, 1,0,1, 128,0,128, 1'b1,1'b0);
        send(255,0,0, 0,-256,0, 0,0,0, -65536, 255,-256,0, 254,256,0, 1'b0,1'b0);
        send(1,2,3, 4,5,6, 7,8,9, 16, 1,-1,2, -80,-176,-272, 1'b0,1'b0);
        send(-129,0,0, 0,0,0, 0,0,0, 256, 1,0,0, 129,0,0, 1'b0,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, 8, 1,0,0, -128,0,0, 1'b1,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, 8, 2,-1,0, -256,128,0, 1'b0,1'b0);
        repeat (10) @(negedge iclk);
        exp_q.delete();
        ov0 = n_ov;
        irst = 1'b1;
        #1;
        chk("abort_ovalid", ovalid, 0);
        chk("abort_oready", oready, 1);
        chk("abort_off_x", $signed(ooff_x), 0);
        chk("abort_off_y", $signed(ooff_y), 0);
        chk("abort_okeep", okeep, 0);
        @(negedge iclk);
        irst = 1'b0;
        last_acc = -1;
        repeat (40) @(negedge iclk);
        chk("no_ovalid_after_abort", n_ov - ov0, 0);
        send(4,0,0, 0,4,0, 0,0,4, 8, 1,0,0, -128,0,0, 1'b1,1'b0);
        send(4,0,0, 0,4,0, 0,0,4, 0, 5,5,5, 0,0,0, 1'b0,1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge iclk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk += exp_q.size();
            n_err += exp_q.size();
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
